// File: rtl/chess_pkg.sv
// Shared piece codes, response codes and sequencer states for the move-check path.
package chess_pkg;

  localparam logic [3:0] W_ROOK   = 4'd0;
  localparam logic [3:0] W_KNIGHT = 4'd1;
  localparam logic [3:0] W_BISHOP = 4'd2;
  localparam logic [3:0] W_QUEEN  = 4'd3;
  localparam logic [3:0] W_KING   = 4'd4;
  localparam logic [3:0] W_PAWN   = 4'd5;
  localparam logic [3:0] B_ROOK   = 4'd6;
  localparam logic [3:0] B_KNIGHT = 4'd7;
  localparam logic [3:0] B_BISHOP = 4'd8;
  localparam logic [3:0] B_QUEEN  = 4'd9;
  localparam logic [3:0] B_KING   = 4'd10;
  localparam logic [3:0] B_PAWN   = 4'd11;
  localparam logic [3:0] EMPTY    = 4'd12;

  typedef enum logic [1:0] {
    OK      = 2'd0,
    ILLEGAL = 2'd1,
    BAD_SRC = 2'd2,
    TIMEOUT = 2'd3
  } rsp_code_t;

  typedef enum logic [2:0] {IDLE, FETCH, SCREEN, ISSUE, WAIT, RESP} seq_state_t;

  // Codes 13..15 are unused and read as empty squares.
  function automatic logic is_empty(logic [3:0] p);
    return p >= EMPTY;
  endfunction

  function automatic logic is_black(logic [3:0] p);
    return (p >= B_ROOK) && (p <= B_PAWN);
  endfunction

endpackage

// File: rtl/move_check_sequencer_if.sv
// Request, board, validator and response signals of the move-check sequencer.
interface move_check_sequencer_if;
  logic                       mv_req_valid;
  logic                       mv_req_ready;
  logic [2:0]                 mv_old_x;
  logic [2:0]                 mv_old_y;
  logic [2:0]                 mv_new_x;
  logic [2:0]                 mv_new_y;
  logic [7:0][7:0][3:0]       board_in;
  logic [3:0]                 val_piece_type;
  logic [2:0]                 val_old_x;
  logic [2:0]                 val_old_y;
  logic [2:0]                 val_new_x;
  logic [2:0]                 val_new_y;
  logic                       val_valid_input;
  logic                       val_valid_move;
  logic                       val_valid_output;
  logic                       rsp_valid;
  logic [1:0]                 rsp_code;
  logic                       commit_valid;
  logic                       side_to_move;

  // Sequencer side.
  modport slave (
    input  mv_req_valid, mv_old_x, mv_old_y, mv_new_x, mv_new_y, board_in,
    input  val_valid_move, val_valid_output,
    output mv_req_ready, val_piece_type, val_old_x, val_old_y, val_new_x, val_new_y,
    output val_valid_input, rsp_valid, rsp_code, commit_valid, side_to_move
  );

  // Requester / validator / board side.
  modport master (
    output mv_req_valid, mv_old_x, mv_old_y, mv_new_x, mv_new_y, board_in,
    output val_valid_move, val_valid_output,
    input  mv_req_ready, val_piece_type, val_old_x, val_old_y, val_new_x, val_new_y,
    input  val_valid_input, rsp_valid, rsp_code, commit_valid, side_to_move
  );
endinterface

// File: rtl/move_screen.sv
// Combinational pre-validator screening of a move request.
// MOVE_CHECK_KING_EN: check king steps locally instead of rejecting every king move.
module move_screen
  import chess_pkg::*;
(
  input  logic [3:0] piece_i,
  input  logic [3:0] dest_i,
  input  logic [2:0] old_x_i,
  input  logic [2:0] old_y_i,
  input  logic [2:0] new_x_i,
  input  logic [2:0] new_y_i,
  input  logic       side_i,
  output logic       issue_o,
  output rsp_code_t  code_o
);

`ifdef MOVE_CHECK_KING_EN
  logic [2:0] dx, dy;
  logic       king_ok;
  assign dx      = (old_x_i > new_x_i) ? old_x_i - new_x_i : new_x_i - old_x_i;
  assign dy      = (old_y_i > new_y_i) ? old_y_i - new_y_i : new_y_i - old_y_i;
  assign king_ok = (dx <= 3'd1) && (dy <= 3'd1);
`else
  // The validator has no king rule, so kings can never be approved.
  logic king_ok;
  assign king_ok = 1'b0;
`endif

  always_comb begin
    issue_o = 1'b0;
    code_o  = OK;
    if (is_empty(piece_i) || (is_black(piece_i) != side_i)) begin
      code_o = BAD_SRC;
    end else if ((old_x_i == new_x_i) && (old_y_i == new_y_i)) begin
      code_o = ILLEGAL;
    end else if (!is_empty(dest_i) && (is_black(dest_i) == is_black(piece_i))) begin
      code_o = ILLEGAL;
    end else if ((piece_i == W_KING) || (piece_i == B_KING)) begin
      code_o = king_ok ? OK : ILLEGAL;
    end else begin
      issue_o = 1'b1;
    end
  end

endmodule

// File: rtl/move_check_sequencer.sv
// Sequences one move request through screening and the piece-rule validator.
// Optional macro MOVE_CHECK_KING_EN enables in-block king step checking (see move_screen).
module move_check_sequencer
  import chess_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned TMR_W       = 7
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   new_game,
  move_check_sequencer_if.slave  bus
);

  seq_state_t       state_q;
  logic [2:0]       old_x_q, old_y_q, new_x_q, new_y_q;
  logic [3:0]       piece_q, dest_q;
  logic [TMR_W-1:0] timer_q;
  logic             side_q;
  logic             val_start_q;
  logic             rsp_valid_q;
  logic             commit_q;
  rsp_code_t        rsp_code_q;

  logic             scr_issue;
  rsp_code_t        scr_code;

  move_screen u_screen (
    .piece_i (piece_q),
    .dest_i  (dest_q),
    .old_x_i (old_x_q),
    .old_y_i (old_y_q),
    .new_x_i (new_x_q),
    .new_y_i (new_y_q),
    .side_i  (side_q),
    .issue_o (scr_issue),
    .code_o  (scr_code)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      old_x_q     <= '0;
      old_y_q     <= '0;
      new_x_q     <= '0;
      new_y_q     <= '0;
      piece_q     <= EMPTY;
      dest_q      <= EMPTY;
      timer_q     <= '0;
      side_q      <= 1'b0;
      val_start_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      commit_q    <= 1'b0;
      rsp_code_q  <= OK;
    end else begin
      val_start_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      commit_q    <= 1'b0;
      if (new_game) begin
        state_q <= IDLE;
        side_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (bus.mv_req_valid) begin
              old_x_q <= bus.mv_old_x;
              old_y_q <= bus.mv_old_y;
              new_x_q <= bus.mv_new_x;
              new_y_q <= bus.mv_new_y;
              state_q <= FETCH;
            end
          end
          FETCH: begin
            piece_q <= bus.board_in[old_y_q][old_x_q];
            dest_q  <= bus.board_in[new_y_q][new_x_q];
            state_q <= SCREEN;
          end
          SCREEN: begin
            if (scr_issue) begin
              val_start_q <= 1'b1;
              state_q     <= ISSUE;
            end else begin
              rsp_valid_q <= 1'b1;
              rsp_code_q  <= scr_code;
              commit_q    <= (scr_code == OK);
              state_q     <= RESP;
            end
          end
          ISSUE: begin
            timer_q <= '0;
            state_q <= WAIT;
          end
          WAIT: begin
            // A done arriving on the last allowed cycle still beats the timeout.
            if (bus.val_valid_output) begin
              rsp_valid_q <= 1'b1;
              rsp_code_q  <= bus.val_valid_move ? OK : ILLEGAL;
              commit_q    <= bus.val_valid_move;
              state_q     <= RESP;
            end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
              rsp_valid_q <= 1'b1;
              rsp_code_q  <= TIMEOUT;
              state_q     <= RESP;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
          RESP: begin
            if (rsp_code_q == OK) side_q <= ~side_q;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // new_game must also squash a response already sitting in the output register.
  assign bus.mv_req_ready    = (state_q == IDLE) && !new_game;
  assign bus.rsp_valid       = rsp_valid_q && !new_game;
  assign bus.commit_valid    = commit_q && !new_game;
  assign bus.rsp_code        = rsp_code_q;
  assign bus.val_valid_input = val_start_q;
  assign bus.val_piece_type  = piece_q;
  assign bus.val_old_x       = old_x_q;
  assign bus.val_old_y       = old_y_q;
  assign bus.val_new_x       = new_x_q;
  assign bus.val_new_y       = new_y_q;
  assign bus.side_to_move    = side_q;

endmodule

// File: tb/tb_move_check_sequencer.sv
// Directed self-checking bench for move_check_sequencer with a latency-programmable stub validator.
module tb_move_check_sequencer;
  import chess_pkg::*;

  logic clk;
  logic reset_n;
  logic new_game;
  logic [7:0][7:0][3:0] board;
  int   stub_lat  = 2;
  int   stub_cnt  = 0;
  int   pulse_cnt = 0;
  logic stub_move = 1'b1;
  int   n_asserts = 0;
  int   n_fail    = 0;
  int   base;
  int   cyc;
  logic saw;

  move_check_sequencer_if bus ();

  move_check_sequencer #(
    .TIMEOUT_CYC (64),
    .TMR_W       (7)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .new_game (new_game),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.board_in         = board;
  assign bus.val_valid_move   = stub_move;
  assign bus.val_valid_output = (stub_cnt == 1);

  // Stub validator: done is high exactly stub_lat cycles after the start pulse; 0 = never.
  always @(posedge clk) begin
    if (bus.val_valid_input && stub_lat > 0) stub_cnt <= stub_lat;
    else if (stub_cnt > 0) stub_cnt <= stub_cnt - 1;
    if (bus.val_valid_input) pulse_cnt <= pulse_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Leaves the bench in cycle 1 (the cycle after the accept edge).
  task automatic send(input logic [2:0] ox, input logic [2:0] oy,
                      input logic [2:0] nx, input logic [2:0] ny);
    bus.mv_old_x     = ox;
    bus.mv_old_y     = oy;
    bus.mv_new_x     = nx;
    bus.mv_new_y     = ny;
    bus.mv_req_valid = 1'b1;
    tick();
    bus.mv_req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int limit, output int c);
    c = 1;
    while (!bus.rsp_valid && c < limit) begin
      tick();
      c++;
    end
  endtask

  initial begin
    reset_n          = 1'b0;
    new_game         = 1'b0;
    bus.mv_req_valid = 1'b0;
    bus.mv_old_x     = '0;
    bus.mv_old_y     = '0;
    bus.mv_new_x     = '0;
    bus.mv_new_y     = '0;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) board[y][x] = EMPTY;
    board[0][0] = W_ROOK;
    board[1][0] = W_KNIGHT;
    board[2][0] = W_PAWN;
    board[0][4] = W_KING;
    board[6][3] = B_PAWN;

    tick();
    tick();
    chk("rst_side", bus.side_to_move, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_commit", bus.commit_valid, 0);
    chk("rst_val_start", bus.val_valid_input, 0);
    chk("rst_code", bus.rsp_code, 0);
    chk("rst_piece", bus.val_piece_type, 12);
    chk("rst_old_y", bus.val_old_y, 0);
    chk("rst_ready", bus.mv_req_ready, 1);
    reset_n = 1'b1;
    tick();

    // White knight, validator approves two cycles after the pulse.
    base = pulse_cnt;
    send(3'd0, 3'd1, 3'd2, 3'd0);
    chk("kn_ready_busy", bus.mv_req_ready, 0);
    wait_rsp(20, cyc);
    chk("kn_cycle", cyc, 6);
    chk("kn_rsp_valid", bus.rsp_valid, 1);
    chk("kn_code", bus.rsp_code, 0);
    chk("kn_commit", bus.commit_valid, 1);
    chk("kn_piece", bus.val_piece_type, 1);
    chk("kn_new_x", bus.val_new_x, 2);
    chk("kn_old_y", bus.val_old_y, 1);
    chk("kn_pulses", pulse_cnt - base, 1);
    tick();
    chk("kn_rsp_drop", bus.rsp_valid, 0);
    chk("kn_side", bus.side_to_move, 1);
    chk("kn_ready_idle", bus.mv_req_ready, 1);

    new_game = 1'b1;
    #1;
    chk("ng_ready_low", bus.mv_req_ready, 0);
    tick();
    new_game = 1'b0;
    chk("ng_side", bus.side_to_move, 0);

    // White to move, source is a black pawn.
    base = pulse_cnt;
    send(3'd3, 3'd6, 3'd3, 3'd5);
    wait_rsp(20, cyc);
    chk("bs_cycle", cyc, 3);
    chk("bs_code", bus.rsp_code, 2);
    chk("bs_commit", bus.commit_valid, 0);
    tick();
    chk("bs_pulses", pulse_cnt - base, 0);
    chk("bs_side", bus.side_to_move, 0);

    // Rook onto own pawn, then a null move.
    base = pulse_cnt;
    send(3'd0, 3'd0, 3'd0, 3'd2);
    wait_rsp(20, cyc);
    chk("own_cycle", cyc, 3);
    chk("own_code", bus.rsp_code, 1);
    chk("own_commit", bus.commit_valid, 0);
    tick();
    send(3'd0, 3'd0, 3'd0, 3'd0);
    wait_rsp(20, cyc);
    chk("null_cycle", cyc, 3);
    chk("null_code", bus.rsp_code, 1);
    tick();
    chk("illegal_pulses", pulse_cnt - base, 0);
    chk("illegal_side", bus.side_to_move, 0);

    // Validator never answers: WAIT entered at cycle 4, timeout response at cycle 68.
    stub_lat = 0;
    base = pulse_cnt;
    send(3'd0, 3'd1, 3'd2, 3'd0);
    wait_rsp(100, cyc);
    chk("to_cycle", cyc, 68);
    chk("to_rsp_valid", bus.rsp_valid, 1);
    chk("to_code", bus.rsp_code, 3);
    chk("to_commit", bus.commit_valid, 0);
    chk("to_pulses", pulse_cnt - base, 1);
    tick();
    chk("to_side", bus.side_to_move, 0);

    // Done on the last WAIT cycle must win over the timeout.
    stub_lat = 64;
    send(3'd0, 3'd1, 3'd2, 3'd0);
    wait_rsp(100, cyc);
    chk("edge_cycle", cyc, 68);
    chk("edge_code", bus.rsp_code, 0);
    chk("edge_commit", bus.commit_valid, 1);
    tick();
    chk("edge_side", bus.side_to_move, 1);

    // new_game in WAIT; the late done must be ignored.
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    stub_lat = 2;
    send(3'd0, 3'd1, 3'd2, 3'd0);
    tick();
    tick();
    tick();
    new_game = 1'b1;
    tick();
    chk("ab_done_seen", bus.val_valid_output, 1);
    chk("ab_rsp_valid", bus.rsp_valid, 0);
    chk("ab_side", bus.side_to_move, 0);
    new_game = 1'b0;
    #1;
    chk("ab_ready", bus.mv_req_ready, 1);
    saw = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.rsp_valid || bus.commit_valid) saw = 1'b1;
    end
    chk("ab_no_rsp", saw, 0);

    // King one step forward.
    base = pulse_cnt;
    send(3'd4, 3'd0, 3'd4, 3'd1);
    wait_rsp(20, cyc);
    chk("king_cycle", cyc, 3);
`ifdef MOVE_CHECK_KING_EN
    chk("king_code", bus.rsp_code, 0);
    chk("king_commit", bus.commit_valid, 1);
    tick();
    chk("king_side", bus.side_to_move, 1);
`else
    chk("king_code", bus.rsp_code, 1);
    chk("king_commit", bus.commit_valid, 0);
    tick();
    chk("king_side", bus.side_to_move, 0);
`endif
    chk("king_pulses", pulse_cnt - base, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
